// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED activity arbiter.
// Build option: LED_ARB_IDX_BLINK_EN (index blink mode, see top module).
package led_arb_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Index width for a channel count n (n >= 2).
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_activity_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward
// from last+1, wrapping N_CH-1 -> 0.
module rr_pick
  import led_arb_pkg::*;
#(
  parameter int N_CH = 4
) (
  input  logic [N_CH-1:0]        req,
  input  logic [clog2(N_CH)-1:0] last,
  output logic                   gnt_valid,
  output logic [clog2(N_CH)-1:0] gnt_idx
);

  localparam int IDX_W = clog2(N_CH);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    // i = N_CH wraps back to last itself, so it is searched last.
    for (int i = 1; i <= N_CH; i++) begin
      cand     = (int'(last) + i) % N_CH;
      cand_idx = IDX_W'(cand);
      if (!gnt_valid && req[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/led_activity_arbiter.sv
// Round-robin scheduler sharing one active-low LED between N_CH activity sources.
// Define LED_ARB_IDX_BLINK_EN to blink channel k as k+1 on-windows per service.
module led_activity_arbiter
  import led_arb_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int ON_CLK  = 10000,
  parameter int GAP_CLK = 5000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_CH-1:0]        activity,
  output logic                   led_n,
  output logic                   busy,
  output logic [clog2(N_CH)-1:0] owner,
  output logic [N_CH-1:0]        pending
);

  localparam int               IDX_W    = clog2(N_CH);
  localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CLK - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CLK - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] owner_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [N_CH-1:0]  pending_d;
  logic [N_CH-1:0]  grant_mask;
  logic             grant;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;
  logic             blink_more;

`ifdef LED_ARB_IDX_BLINK_EN
  logic [IDX_W-1:0] blink_q, blink_d;
  assign blink_more = (blink_q != '0);
`else
  assign blink_more = 1'b0;
`endif

  rr_pick #(.N_CH(N_CH)) u_pick (
    .req      (pending),
    .last     (last_q),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner;
    last_d     = last_q;
    grant      = 1'b0;
    grant_mask = '0;
`ifdef LED_ARB_IDX_BLINK_EN
    blink_d    = blink_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) grant = 1'b1;
      end
      ST_ON: begin
        if (cnt_q == '0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (blink_more) begin
          // Another blink for the same owner takes precedence over new grants.
          state_d = ST_ON;
          cnt_d   = ON_LOAD;
`ifdef LED_ARB_IDX_BLINK_EN
          blink_d = blink_q - IDX_W'(1);
`endif
        end else if (gnt_valid) begin
          grant = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (grant) begin
      state_d    = ST_ON;
      cnt_d      = ON_LOAD;
      owner_d    = gnt_idx;
      last_d     = gnt_idx;
      grant_mask = N_CH'(1) << gnt_idx;
`ifdef LED_ARB_IDX_BLINK_EN
      blink_d    = gnt_idx;
`endif
    end

    // Fresh activity wins over the grant clear, re-queuing the granted channel.
    pending_d = (pending & ~grant_mask) | activity;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      owner   <= '0;
      last_q  <= IDX_W'(N_CH - 1);
      pending <= '0;
`ifdef LED_ARB_IDX_BLINK_EN
      blink_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner   <= owner_d;
      last_q  <= last_d;
      pending <= pending_d;
`ifdef LED_ARB_IDX_BLINK_EN
      blink_q <= blink_d;
`endif
    end
  end

  // Decoded straight from the state register so reset darkens the LED at once.
  assign led_n = (state_q != ST_ON);
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_led_activity_arbiter.sv
// Directed self-checking bench for led_activity_arbiter (N_CH=4, ON_CLK=4, GAP_CLK=2).
module tb_led_activity_arbiter;

  localparam int N_CH    = 4;
  localparam int ON_CLK  = 4;
  localparam int GAP_CLK = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] activity = '0;
  logic       led_n;
  logic       busy;
  logic [1:0] owner;
  logic [3:0] pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_activity_arbiter #(
    .N_CH   (N_CH),
    .ON_CLK (ON_CLK),
    .GAP_CLK(GAP_CLK)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .activity(activity),
    .led_n   (led_n),
    .busy    (busy),
    .owner   (owner),
    .pending (pending)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    activity = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic pulse(input logic [3:0] a);
    activity = a;
    tick();
    activity = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int low;
    int bsy;
    int falls;
    logic prev;
    logic [3:0] exp_pend;

    // Reset state, with activity driven to show nothing latches under reset.
    reset_n  = 1'b0;
    activity = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    check("rst_led_n",   32'(led_n),   32'd1);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_owner",   32'(owner),   32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    activity = '0;
    reset_n  = 1'b1;

    // 1: single pulse -> 4 lit, 2 dark, idle.
    pulse(4'b0001);
    check("t1_pend_latch", 32'(pending), 32'h1);
    check("t1_idle_led",   32'(led_n),   32'd1);
    low = 0;
    bsy = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!led_n) low++;
      if (busy) bsy++;
      if (i == 0) begin
        check("t1_first_lit", 32'(led_n), 32'd0);
        check("t1_owner",     32'(owner), 32'd0);
      end
      if (i == 4) check("t1_gap_dark", 32'(led_n), 32'd1);
    end
    check("t1_on_cycles",   low, 32'd4);
    check("t1_busy_cycles", bsy, 32'd6);
    check("t1_end_busy",    32'(busy), 32'd0);

    // 2: all channels at once -> rotation 0,1,2,3 without idle cycles.
    do_reset();
    pulse(4'b1111);
    bsy = 0;
    for (int s = 0; s < 4; s++) begin
      tick();
      if (busy) bsy++;
      exp_pend = 4'hF << (s + 1);
      check("t2_owner",   32'(owner),   32'(s));
      check("t2_pending", 32'(pending), 32'(exp_pend));
      check("t2_lit",     32'(led_n),   32'd0);
      repeat (5) begin
        tick();
        if (busy) bsy++;
      end
    end
    check("t2_busy_cycles", bsy, 32'd24);
    tick();
    check("t2_idle", 32'(busy), 32'd0);

    // 3: re-request during own ON window only queues.
    do_reset();
    pulse(4'b0100);
    tick();
    check("t3_owner", 32'(owner), 32'd2);
    activity = 4'b0100;
    tick();
    activity = '0;
    tick();
    check("t3_pend_set", 32'(pending), 32'h4);
    tick();
    tick();
    check("t3_not_extended", 32'(led_n),   32'd1);
    check("t3_pend_held",    32'(pending), 32'h4);
    tick();
    check("t3_gap2_dark", 32'(led_n), 32'd1);
    tick();
    check("t3_reserve_lit",   32'(led_n),   32'd0);
    check("t3_reserve_owner", 32'(owner),   32'd2);
    check("t3_pend_clear",    32'(pending), 32'h0);
    repeat (6) tick();
    check("t3_idle", 32'(busy), 32'd0);

    // 4: asynchronous reset mid-ON.
    do_reset();
    pulse(4'b1010);
    activity = 4'b1010;
    tick();
    activity = '0;
    check("t4_owner_pre", 32'(owner),   32'd1);
    check("t4_pend_pre",  32'(pending), 32'hA);
    check("t4_lit_pre",   32'(led_n),   32'd0);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_async_dark", 32'(led_n),   32'd1);
    check("t4_pend_clr",   32'(pending), 32'h0);
    check("t4_owner_clr",  32'(owner),   32'd0);
    check("t4_busy_clr",   32'(busy),    32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bsy = 0;
    repeat (10) begin
      tick();
      if (busy || !led_n) bsy++;
    end
    check("t4_no_service", bsy, 32'd0);

    // 6: activity held through the grant cycle re-queues the channel.
    do_reset();
    activity = 4'b0001;
    tick();
    tick();
    activity = '0;
    check("t6_owner",   32'(owner),   32'd0);
    check("t6_lit",     32'(led_n),   32'd0);
    check("t6_requeue", 32'(pending), 32'h1);
    repeat (5) tick();
    tick();
    check("t6_second_lit",  32'(led_n),   32'd0);
    check("t6_second_pend", 32'(pending), 32'h0);
    repeat (5) tick();
    tick();
    check("t6_idle", 32'(busy), 32'd0);

    // 5: channel 3 service, blink count depends on build option.
    do_reset();
    pulse(4'b1000);
    low   = 0;
    falls = 0;
    prev  = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!led_n) low++;
      if (prev && !led_n) falls++;
      prev = led_n;
      if (i == 0) check("t5_owner", 32'(owner), 32'd3);
    end
`ifdef LED_ARB_IDX_BLINK_EN
    check("t5_on_cycles", low,   32'd16);
    check("t5_windows",   falls, 32'd4);
`else
    check("t5_on_cycles", low,   32'd4);
    check("t5_windows",   falls, 32'd1);
`endif
    check("t5_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
